sr_exc_driver: RTL and testbench



---
 rtl/sr_exc_pkg.sv | 23 ++
 rtl/sr_exc_encode.sv | 36 +++
 rtl/sr_exc_driver.sv | 135 +++++++++++++
 tb/tb_sr_exc_driver.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_exc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_exc_pkg
// Purpose  : Shared definitions for the SR flip-flop excitation driver:
//            the transfer FSM state encoding and default lane/counter widths.
// Ports    : none (package)
// Config   : none here; SR_EXC_FORCE_EN is consumed by sr_exc_encode.
// Revision : 1.0 - initial release
// ============================================================================
package sr_exc_pkg;

  localparam int SR_EXC_W_DEFAULT     = 8;
  localparam int SR_EXC_ERR_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sr_exc_encode.sv
`default_nettype none
// ============================================================================
// Module   : sr_exc_encode
// Purpose  : One-lane SR excitation encoder. Given the requested state and
//            the modelled current state, produces S/R inputs that move the
//            flop to the target without ever asserting S and R together.
// Ports    : tgt (in)  requested flop state
//            cur (in)  modelled current flop state
//            s   (out) set excitation
//            r   (out) reset excitation
// Config   : SR_EXC_FORCE_EN defined   -> forced drive (s=tgt, r=~tgt)
//            SR_EXC_FORCE_EN undefined -> minimal drive (only changing lanes)
// Revision : 1.0 - initial release
// ============================================================================
module sr_exc_encode (
  input  logic tgt,
  input  logic cur,
  output logic s,
  output logic r
);

`ifdef SR_EXC_FORCE_EN
  // Every lane is re-asserted so a drifted flop is pulled back; cur is
  // deliberately ignored in this build.
  logic unused_cur;
  assign unused_cur = cur;
  assign s = tgt;
  assign r = ~tgt;
`else
  // Only lanes that change get excited; unchanged lanes hold (s=r=0).
  assign s = tgt & ~cur;
  assign r = ~tgt & cur;
`endif

endmodule
`default_nettype wire

// File: rtl/sr_exc_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_exc_driver
// Purpose  : Excitation-side driver for a bank of W SR flip-flops. Accepts a
//            target vector over valid/ready, drives legal S/R for one cycle,
//            checks the flops' q one cycle later, reports done/err_flag and
//            keeps a saturating count of failed transfers.
// Ports    : clk        (in)  clock, rising edge
//            rst_n      (in)  synchronous active-low reset
//            tgt_valid  (in)  target offered
//            tgt_ready  (out) idle, target can be accepted
//            tgt_data   (in)  requested flop state [W]
//            s, r       (out) set / reset excitation [W]
//            q_fb       (in)  flop bank q feedback [W]
//            done       (out) one-cycle transfer-complete pulse
//            err_flag   (out) mismatch flag, valid with done
//            err_cnt    (out) saturating mismatch counter [ERR_W]
// Config   : SR_EXC_FORCE_EN selects forced excitation (see sr_exc_encode)
// Revision : 1.0 - initial release
// ============================================================================
module sr_exc_driver
  import sr_exc_pkg::*;
#(
  parameter int W     = SR_EXC_W_DEFAULT,
  parameter int ERR_W = SR_EXC_ERR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [W-1:0]     tgt_data,
  output logic [W-1:0]     s,
  output logic [W-1:0]     r,
  input  logic [W-1:0]     q_fb,
  output logic             done,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt
);

  state_t           state_q, state_d;
  logic [W-1:0]     tgt_q;
  logic [W-1:0]     q_model;
  logic [W-1:0]     s_q, r_q;
  logic [W-1:0]     enc_s, enc_r;
  logic             ready_q;
  logic             done_q;
  logic             err_flag_q;
  logic [ERR_W-1:0] err_cnt_q;

  // Excitation is computed from the incoming target against the model of
  // what the flops currently hold, then registered on acceptance.
  for (genvar i = 0; i < W; i++) begin : g_lane
    sr_exc_encode u_enc (
      .tgt (tgt_data[i]),
      .cur (q_model[i]),
      .s   (enc_s[i]),
      .r   (enc_r[i])
    );
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tgt_valid) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_CHECK;
      ST_CHECK:  state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_q      <= '0;
      q_model    <= '0;
      s_q        <= '0;
      r_q        <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      // Excitation lives for the DRIVE cycle only; cleared everywhere else.
      s_q        <= '0;
      r_q        <= '0;
      done_q     <= 1'b0;
      err_flag_q <= 1'b0;
      // Ready is registered from the next state so it is high exactly
      // in IDLE cycles without a combinational path from tgt_valid.
      ready_q    <= (state_d == ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (tgt_valid) begin
            tgt_q <= tgt_data;
            s_q   <= enc_s;
            r_q   <= enc_r;
          end
        end
        ST_DRIVE: begin
          // Model follows the accepted target, never the observed q.
          q_model <= tgt_q;
        end
        ST_CHECK: begin
          done_q     <= 1'b1;
          err_flag_q <= (q_fb != tgt_q);
        end
        ST_REPORT: begin
          if (err_flag_q && (err_cnt_q != {ERR_W{1'b1}}))
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign tgt_ready = ready_q;
  assign s         = s_q;
  assign r         = r_q;
  assign done      = done_q;
  assign err_flag  = err_flag_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_exc_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_exc_driver
// Purpose  : Self-checking directed bench for sr_exc_driver (W=8, ERR_W=2)
//            with a behavioural SR flop bank in the loop and an optional
//            stuck-at mask on the q feedback.
// Ports    : none
// Config   : honours SR_EXC_FORCE_EN for expected excitation values
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_exc_driver;

  localparam int W     = 8;
  localparam int ERR_W = 2;

  logic             clk;
  logic             rst_n;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [W-1:0]     tgt_data;
  logic [W-1:0]     s, r;
  logic [W-1:0]     q_fb;
  logic             done;
  logic             err_flag;
  logic [ERR_W-1:0] err_cnt;

  logic [W-1:0]     q_bank;
  logic [W-1:0]     stuck_mask;
  logic [W-1:0]     prev_tgt;

  int total;
  int bad;

  // observations captured by run_xfer
  logic [W-1:0]     o_drv_s, o_drv_r, o_chk_s, o_chk_r;
  logic             o_drv_ready, o_chk_done, o_done, o_flag, o_post_done, o_post_ready;
  logic [ERR_W-1:0] o_cnt;

  sr_exc_driver #(.W(W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .done      (done),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SR flop bank, reset to 0 together with the driver.
  always @(posedge clk) begin
    if (!rst_n) q_bank <= '0;
    else        q_bank <= (q_bank | s) & ~r;
  end
  assign q_fb = q_bank & ~stuck_mask;

  function automatic logic [W-1:0] exp_s(input logic [W-1:0] t, input logic [W-1:0] p);
`ifdef SR_EXC_FORCE_EN
    return t;
`else
    return t & ~p;
`endif
  endfunction

  function automatic logic [W-1:0] exp_r(input logic [W-1:0] t, input logic [W-1:0] p);
`ifdef SR_EXC_FORCE_EN
    return ~t;
`else
    return ~t & p;
`endif
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    prev_tgt = '0;
  endtask

  // Offers one target and records the outputs in each phase of the transfer.
  task automatic run_xfer(input logic [W-1:0] d);
    int n;
    n = 0;
    while (!tgt_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tgt_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: tgt_ready=%b required=1", tgt_ready);
    end
    tgt_valid = 1'b1;
    tgt_data  = d;
    @(negedge clk);
    o_drv_s = s; o_drv_r = r; o_drv_ready = tgt_ready;
    tgt_valid = 1'b0;
    tgt_data  = W'($urandom);
    @(negedge clk);
    o_chk_s = s; o_chk_r = r; o_chk_done = done;
    @(negedge clk);
    o_done = done; o_flag = err_flag;
    @(negedge clk);
    o_post_done = done; o_cnt = err_cnt; o_post_ready = tgt_ready;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    stuck_mask = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({s, r} !== '0) begin bad++; $display("FAIL reset_sr: s=%h r=%h required 00/00", s, r); end
    total++;
    if ({done, err_flag} !== 2'b00) begin bad++; $display("FAIL reset_done: done=%b err_flag=%b required 0/0", done, err_flag); end
    total++;
    if (err_cnt !== '0) begin bad++; $display("FAIL reset_cnt: err_cnt=%0d required 0", err_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (tgt_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: tgt_ready=%b required 1", tgt_ready); end
    prev_tgt = '0;
  endtask

  task automatic test_first_transfer();
    run_xfer(8'hA5);
    total++;
    if (o_drv_s !== exp_s(8'hA5, 8'h00) || o_drv_r !== exp_r(8'hA5, 8'h00)) begin
      bad++; $display("FAIL first_drive: s=%h r=%h required %h/%h", o_drv_s, o_drv_r, exp_s(8'hA5, 8'h00), exp_r(8'hA5, 8'h00));
    end
    total++;
    if (o_drv_ready !== 1'b0) begin bad++; $display("FAIL first_busy: tgt_ready=%b required 0", o_drv_ready); end
    total++;
    if (o_chk_s !== 8'h00 || o_chk_r !== 8'h00) begin bad++; $display("FAIL first_check_sr: s=%h r=%h required 00/00", o_chk_s, o_chk_r); end
    total++;
    if (o_chk_done !== 1'b0 || o_done !== 1'b1 || o_post_done !== 1'b0) begin
      bad++; $display("FAIL first_done: done c2/c3/c4=%b%b%b required 010", o_chk_done, o_done, o_post_done);
    end
    total++;
    if (o_flag !== 1'b0) begin bad++; $display("FAIL first_flag: err_flag=%b required 0", o_flag); end
    total++;
    if (o_post_ready !== 1'b1) begin bad++; $display("FAIL first_ready_again: tgt_ready=%b required 1", o_post_ready); end
    total++;
    if (q_bank !== 8'hA5) begin bad++; $display("FAIL first_bank: q=%h required a5", q_bank); end
    prev_tgt = 8'hA5;
  endtask

  task automatic test_change_vector();
    logic [W-1:0] es, er;
`ifdef SR_EXC_FORCE_EN
    es = 8'h3C; er = 8'hC3;
`else
    es = 8'h18; er = 8'h81;
`endif
    run_xfer(8'h3C);
    total++;
    if (o_drv_s !== es || o_drv_r !== er) begin
      bad++; $display("FAIL change_drive: s=%h r=%h required %h/%h", o_drv_s, o_drv_r, es, er);
    end
    total++;
    if (q_bank !== 8'h3C || o_flag !== 1'b0) begin
      bad++; $display("FAIL change_result: q=%h err_flag=%b required 3c/0", q_bank, o_flag);
    end
    prev_tgt = 8'h3C;
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    for (int k = 0; k < 1000; k++) begin
      d = W'($urandom);
      run_xfer(d);
      total++;
      if ((o_drv_s & o_drv_r) !== '0 || (o_chk_s & o_chk_r) !== '0) begin
        bad++; $display("FAIL rand_illegal: k=%0d s&r drive=%h check=%h required 00", k, o_drv_s & o_drv_r, o_chk_s & o_chk_r);
      end
      total++;
      if (o_drv_s !== exp_s(d, prev_tgt) || o_drv_r !== exp_r(d, prev_tgt)) begin
        bad++; $display("FAIL rand_drive: k=%0d s=%h r=%h required %h/%h", k, o_drv_s, o_drv_r, exp_s(d, prev_tgt), exp_r(d, prev_tgt));
      end
      total++;
      if (q_bank !== d || o_done !== 1'b1 || o_flag !== 1'b0) begin
        bad++; $display("FAIL rand_result: k=%0d q=%h done=%b flag=%b required %h/1/0", k, q_bank, o_done, o_flag, d);
      end
      prev_tgt = d;
    end
  endtask

  task automatic test_fault_saturation();
    logic [ERR_W-1:0] ec;
    do_reset();
    stuck_mask = 8'h01;
    for (int k = 0; k < 5; k++) begin
      ec = (k < 2) ? ERR_W'(k + 1) : 2'd3;
      run_xfer(8'h01);
      total++;
      if (o_done !== 1'b1 || o_flag !== 1'b1) begin
        bad++; $display("FAIL fault_flag: k=%0d done=%b err_flag=%b required 1/1", k, o_done, o_flag);
      end
      total++;
      if (o_cnt !== ec) begin
        bad++; $display("FAIL fault_cnt: k=%0d err_cnt=%0d required %0d", k, o_cnt, ec);
      end
      prev_tgt = 8'h01;
    end
    stuck_mask = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!tgt_ready && n < 20) begin @(negedge clk); n++; end
    tgt_valid = 1'b1;
    tgt_data  = 8'hFF;
    @(negedge clk);             // now in DRIVE
    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    @(negedge clk);
    total++;
    if (s !== '0 || r !== '0) begin bad++; $display("FAIL midrst_sr: s=%h r=%h required 00/00", s, r); end
    total++;
    if (done !== 1'b0 || err_cnt !== '0) begin bad++; $display("FAIL midrst_state: done=%b err_cnt=%0d required 0/0", done, err_cnt); end
    rst_n = 1'b1;
    prev_tgt = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || tgt_ready !== 1'b1) begin
        bad++; $display("FAIL midrst_after: k=%0d done=%b tgt_ready=%b required 0/1", k, done, tgt_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      tgt_valid = 1'b1;
      tgt_data  = W'(8'h40 + i * 3);
      total++;
      if (tgt_ready !== (i % 4 == 0)) begin
        bad++; $display("FAIL b2b_ready: i=%0d tgt_ready=%b required %b", i, tgt_ready, (i % 4 == 0));
      end
      if (i % 4 == 0) acc = tgt_data;
      if (i % 4 == 1) begin
        total++;
        if (s !== exp_s(acc, prev_tgt) || r !== exp_r(acc, prev_tgt)) begin
          bad++; $display("FAIL b2b_drive: i=%0d s=%h r=%h required %h/%h", i, s, r, exp_s(acc, prev_tgt), exp_r(acc, prev_tgt));
        end
        prev_tgt = acc;
      end
      if (i % 4 == 3) begin
        total++;
        if (done !== 1'b1 || err_flag !== 1'b0) begin
          bad++; $display("FAIL b2b_done: i=%0d done=%b err_flag=%b required 1/0", i, done, err_flag);
        end
      end
      @(negedge clk);
    end
    tgt_valid = 1'b0;
    total++;
    if (q_bank !== prev_tgt) begin bad++; $display("FAIL b2b_bank: q=%h required %h", q_bank, prev_tgt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    stuck_mask = '0;
    prev_tgt   = '0;
    tgt_valid  = 1'b0;
    tgt_data   = '0;
    rst_n      = 1'b0;
    test_reset();
    test_first_transfer();
    test_change_vector();
    test_random();
    test_fault_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
